// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that time-shares one bank of JK flops between NREQ requesters.
// Optional read-back verification of every op is compiled in with JK_BANK_VERIFY_EN.
module jk_bank_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  input  logic [WIDTH-1:0]        q_in,
  output logic [WIDTH-1:0]        rdata,
  output logic                    done,
  output logic                    err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_mask;
  logic             verify_miss;

  // Modulo-NREQ increment that also works when NREQ is not a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] j_of(input logic [1:0] o, input logic [WIDTH-1:0] m);
    return o[1] ? m : '0;
  endfunction

  function automatic logic [WIDTH-1:0] k_of(input logic [1:0] o, input logic [WIDTH-1:0] m);
    return o[0] ? m : '0;
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(ptr, k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_op   = '0;
    win_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_op   = op[2*i +: 2];
        win_mask = mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // ---- IDLE -> DRIVE -> SETTLE -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      rdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= DRIVE;
            gnt   <= NREQ'(1) << win_idx;
            busy  <= 1'b1;
            j_out <= j_of(win_op, win_mask);
            k_out <= k_of(win_op, win_mask);
            ptr   <= wrap_inc(win_idx, 1);
          end
        end
        DRIVE: begin
          state <= SETTLE;
          j_out <= '0;
          k_out <= '0;
        end
        SETTLE: begin
          state <= IDLE;
          busy  <= 1'b0;
          rdata <= q_in;
          done  <= 1'b1;
          err   <= verify_miss;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_BANK_VERIFY_EN
  logic [1:0]       op_p1;
  logic [WIDTH-1:0] mask_p1;
  logic [WIDTH-1:0] old_p1;

  function automatic logic [WIDTH-1:0] expect_q(input logic [1:0] o, input logic [WIDTH-1:0] m,
                                                input logic [WIDTH-1:0] old);
    case (o)
      2'b01:   return old & ~m;
      2'b10:   return old | m;
      2'b11:   return old ^ m;
      default: return old;
    endcase
  endfunction

  // ---- snapshot at grant; compared against the bank in SETTLE
  always_ff @(posedge clk) begin
    if (state == IDLE && win_vld) begin
      op_p1   <= win_op;
      mask_p1 <= win_mask;
      old_p1  <= q_in;
    end
  end

  assign verify_miss = (q_in != expect_q(op_p1, mask_p1, old_p1));
`else
  assign verify_miss = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched with a behavioural JK bank on j_out/k_out/q_in.
module tb_jk_bank_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
`ifdef JK_BANK_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     op = '0;
  logic [NREQ*WIDTH-1:0] mask = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      j_out, k_out, q_in, rdata;
  logic                  done, err;

  logic [WIDTH-1:0]      bank;
  logic [WIDTH-1:0]      load_val = '0;
  logic                  load = 1'b0;
  logic                  stuck0 = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_bank_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .mask(mask),
    .gnt(gnt), .busy(busy), .j_out(j_out), .k_out(k_out), .q_in(q_in),
    .rdata(rdata), .done(done), .err(err)
  );

  // JK bank: 10 set, 01 clear, 11 toggle, 00 hold
  always @(posedge clk) begin
    if (load) bank <= load_val;
    else      bank <= (j_out & ~k_out) | (j_out & k_out & ~bank) | (~j_out & ~k_out & bank);
  end

  assign q_in = stuck0 ? (bank & 8'hFE) : bank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [WIDTH-1:0] v);
    load_val = v;
    load = 1'b1;
    tick;
    load = 1'b0;
  endtask

  task automatic run_op(input int r, input logic [1:0] opc, input logic [WIDTH-1:0] msk,
                        input logic [WIDTH-1:0] ej, input logic [WIDTH-1:0] ek,
                        input logic [WIDTH-1:0] erd, input logic eerr);
    req = NREQ'(1) << r;
    op[2*r +: 2] = opc;
    mask[WIDTH*r +: WIDTH] = msk;
    tick;
    chk("drv_gnt", 32'(gnt), 32'(NREQ'(1) << r));
    chk("drv_busy", 32'(busy), 1);
    chk("drv_j", 32'(j_out), 32'(ej));
    chk("drv_k", 32'(k_out), 32'(ek));
    chk("drv_done", 32'(done), 0);
    req = '0;
    tick;
    chk("set_j", 32'(j_out), 0);
    chk("set_k", 32'(k_out), 0);
    chk("set_busy", 32'(busy), 1);
    chk("set_gnt", 32'(gnt), 0);
    chk("set_done", 32'(done), 0);
    tick;
    chk("done", 32'(done), 1);
    chk("rdata", 32'(rdata), 32'(erd));
    chk("err", 32'(err), 32'(eerr));
    chk("done_busy", 32'(busy), 0);
    tick;
    chk("done_pulse", 32'(done), 0);
  endtask

  initial begin
    load_val = 8'h00;
    load = 1'b1;
    tick;
    load = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_j", 32'(j_out), 0);
    chk("rst_k", 32'(k_out), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_j", 32'(j_out), 0);
      chk("idle_done", 32'(done), 0);
    end

    // Round-robin with every requester asserting, pointer fresh from reset
    req = '1;
    for (int c = 0; c < 13; c++) begin
      tick;
      chk($sformatf("arb_gnt%0d", c), 32'(gnt),
          (c % 3 == 0) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
      if (c == 12) req = '0;
    end
    tick;
    tick;
    chk("arb_tail_done", 32'(done), 1);
    tick;

    // Set then clear on requester 0
    run_op(0, 2'b10, 8'h0F, 8'h0F, 8'h00, 8'h0F, 1'b0);
    tick;
    chk("rdata_hold", 32'(rdata), 32'h0F);
    run_op(0, 2'b01, 8'h03, 8'h00, 8'h03, 8'h0C, 1'b0);

    // Toggle all bits on requester 2
    load_bank(8'hA5);
    run_op(2, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 1'b0);

    // Empty mask is a plain read
    load_bank(8'h3C);
    run_op(1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b0);

    // Async reset in the middle of DRIVE
    req = 4'b0001;
    op[1:0] = 2'b10;
    mask[7:0] = 8'hFF;
    tick;
    chk("mid_j_before", 32'(j_out), 32'hFF);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_j", 32'(j_out), 0);
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rdata", 32'(rdata), 0);
    chk("mid_done", 32'(done), 0);
    req = '0;
    tick;
    chk("mid_bank", 32'(q_in), 32'h3C);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("post_done", 32'(done), 0);
      chk("post_gnt", 32'(gnt), 0);
      chk("post_j", 32'(j_out), 0);
    end

    // Bit 0 of q_in stuck low: set on bit 0 must be flagged when verification is built in
    stuck0 = 1'b1;
    load_bank(8'h00);
    run_op(3, 2'b10, 8'h01, 8'h01, 8'h00, 8'h00, VERIFY);
    stuck0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
